// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode map, decoded-opcode bit
// positions, instruction field positions and the opcode decode function.
package id_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_INT_LAST    = 7'h07;
    localparam logic [OPC_W-1:0] OPC_INT_NORSV   = 7'h04;
    localparam logic [OPC_W-1:0] OPC_SHIFT_FIRST = 7'h08;
    localparam logic [OPC_W-1:0] OPC_SHIFT_LAST  = 7'h0D;
    localparam logic [OPC_W-1:0] OPC_SHIFT_HOLE  = 7'h0B;
    localparam logic [OPC_W-1:0] OPC_LOGIC_FIRST = 7'h10;
    localparam logic [OPC_W-1:0] OPC_LOGIC_LAST  = 7'h13;
    localparam logic [OPC_W-1:0] OPC_SET_FIRST   = 7'h16;
    localparam logic [OPC_W-1:0] OPC_SET_LAST    = 7'h17;
    localparam logic [OPC_W-1:0] OPC_LD          = 7'h18;
    localparam logic [OPC_W-1:0] OPC_ST          = 7'h19;
    localparam logic [OPC_W-1:0] OPC_BR_FIRST    = 7'h1C;
    localparam logic [OPC_W-1:0] OPC_BR_LAST     = 7'h1D;
    localparam logic [OPC_W-1:0] OPC_JMP_FIRST   = 7'h1E;
    localparam logic [OPC_W-1:0] OPC_JMP_LAST    = 7'h1F;
    localparam logic [OPC_W-1:0] OPC_NOP         = 7'b0011110;

    localparam int unsigned DOPC_INTE  = 0;
    localparam int unsigned DOPC_LOGIC = 1;
    localparam int unsigned DOPC_SHIFT = 2;
    localparam int unsigned DOPC_LD    = 3;
    localparam int unsigned DOPC_ST    = 4;
    localparam int unsigned DOPC_BR    = 5;
    localparam int unsigned DOPC_SET   = 6;
    localparam int unsigned DOPC_IMM16 = 7;
    localparam int unsigned DOPC_RSV   = 8;
    localparam int unsigned DOPC_UND   = 9;
    localparam int unsigned DOPC_W     = 10;

    localparam int unsigned F_OPC_HI = 31;
    localparam int unsigned F_OPC_LO = 25;
    localparam int unsigned F_IMMF   = 24;
    localparam int unsigned F_RD_HI  = 23;
    localparam int unsigned F_RD_LO  = 20;
    localparam int unsigned F_RS_HI  = 19;
    localparam int unsigned F_RS_LO  = 16;
    localparam int unsigned F_IMM_HI = 15;
    localparam int unsigned F_IMM_LO = 0;

    function automatic logic [DOPC_W-1:0] decode(input logic [OPC_W-1:0] opc);
        logic [DOPC_W-1:0] d;
        d = '0;
        if (opc <= OPC_INT_LAST) begin
            d[DOPC_INTE] = 1'b1;
            d[DOPC_RSV]  = (opc != OPC_INT_NORSV);
        end else if (opc >= OPC_SHIFT_FIRST && opc <= OPC_SHIFT_LAST && opc != OPC_SHIFT_HOLE) begin
            d[DOPC_SHIFT] = 1'b1;
            d[DOPC_IMM16] = 1'b1;
            d[DOPC_RSV]   = 1'b1;
        end else if (opc >= OPC_LOGIC_FIRST && opc <= OPC_LOGIC_LAST) begin
            d[DOPC_LOGIC] = 1'b1;
            d[DOPC_RSV]   = 1'b1;
        end else if (opc >= OPC_SET_FIRST && opc <= OPC_SET_LAST) begin
            d[DOPC_SET] = 1'b1;
            d[DOPC_RSV] = 1'b1;
        end else if (opc == OPC_LD) begin
            d[DOPC_LD]  = 1'b1;
            d[DOPC_RSV] = 1'b1;
        end else if (opc == OPC_ST) begin
            d[DOPC_ST] = 1'b1;
        end else if (opc >= OPC_BR_FIRST && opc <= OPC_BR_LAST) begin
            d[DOPC_BR] = 1'b1;
        end else if (!(opc >= OPC_JMP_FIRST && opc <= OPC_JMP_LAST)) begin
            d[DOPC_UND] = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_sb_regfile.sv
// Register file with write-back bypass, per-register reservation scoreboard
// and the read-after-write hazard check for the instruction in decode.
module id_sb_regfile
    import id_pkg::*;
#(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned N_REG  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_addr_i,
    input  logic [3:0]        rs_addr_i,
    input  logic              use_rd_i,
    input  logic              use_rs_i,
    input  logic              inst_valid_i,
    input  logic              sb_set_i,
    input  logic              wb_i,
    input  logic [3:0]        wb_r_i,
    input  logic [W_DATA-1:0] wb_data_i,
    output logic [W_DATA-1:0] rd_data_o,
    output logic [W_DATA-1:0] rs_data_o,
    output logic              hazard_o,
    output logic              sb_busy_o
);

    localparam int unsigned AW = (N_REG > 1) ? $clog2(N_REG) : 1;

    function automatic logic in_range(input logic [3:0] a);
        return {1'b0, a} < 5'(N_REG);
    endfunction

    logic [W_DATA-1:0] regs_q [N_REG];
    logic [N_REG-1:0]  sb_q, sb_d, sb_eff, clr_mask, set_mask;
    logic              wb_ok, rd_ok, rs_ok;

    assign wb_ok = wb_i & in_range(wb_r_i);
    assign rd_ok = in_range(rd_addr_i);
    assign rs_ok = in_range(rs_addr_i);

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_ok) clr_mask[wb_r_i[AW-1:0]] = 1'b1;
        if (sb_set_i && rd_ok) set_mask[rd_addr_i[AW-1:0]] = 1'b1;
    end

    // A reservation released by this cycle's write-back no longer blocks;
    // a same-cycle set on that register still wins.
    assign sb_eff    = sb_q & ~clr_mask;
    assign sb_d      = sb_eff | set_mask;
    assign sb_busy_o = |sb_q;

    assign hazard_o = inst_valid_i &
        ((use_rd_i & rd_ok & sb_eff[rd_addr_i[AW-1:0]]) |
         (use_rs_i & rs_ok & sb_eff[rs_addr_i[AW-1:0]]));

    always_comb begin
        rd_data_o = '0;
        rs_data_o = '0;
        if (rd_ok) begin
            rd_data_o = (wb_ok && wb_r_i == rd_addr_i) ? wb_data_i : regs_q[rd_addr_i[AW-1:0]];
        end
        if (rs_ok) begin
            rs_data_o = (wb_ok && wb_r_i == rs_addr_i) ? wb_data_i : regs_q[rs_addr_i[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
            for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
        end else begin
            sb_q <= sb_d;
            if (wb_ok) regs_q[wb_r_i[AW-1:0]] <= wb_data_i;
        end
    end

endmodule

// File: rtl/id_sb_stage.sv
// Instruction-decode stage: opcode decode, immediate extension, hazard
// interlock against the scoreboard, and the ID/EX pipeline register.
module id_sb_stage
    import id_pkg::*;
#(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned N_REG  = 16,
    parameter int unsigned W_PC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic              inst_valid_i,
    input  logic [W_PC-1:0]   pc_value_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_i,
    input  logic [3:0]        wb_r_i,
    input  logic [W_DATA-1:0] wb_data_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic              ctrl_inte_o,
    output logic              ctrl_logic_o,
    output logic              ctrl_shift_o,
    output logic              ctrl_ld_o,
    output logic              ctrl_st_o,
    output logic              ctrl_br_o,
    output logic              und_o,
    output logic              immf_o,
    output logic [W_DATA-1:0] rd_value_o,
    output logic [W_DATA-1:0] rs_value_o,
    output logic [W_DATA-1:0] imm_value_o,
    output logic [W_PC-1:0]   pc_value_o,
    output logic [6:0]        opcode_o,
    output logic [3:0]        rd_addr_o,
    output logic              rsv_o,
    output logic              sb_busy_o
);

    typedef struct packed {
        logic              valid;
        logic              inte;
        logic              lgc;
        logic              shift;
        logic              ld;
        logic              st;
        logic              br;
        logic              und;
        logic              immf;
        logic              rsv;
        logic [W_DATA-1:0] rd_value;
        logic [W_DATA-1:0] rs_value;
        logic [W_DATA-1:0] imm_value;
        logic [W_PC-1:0]   pc;
        logic [6:0]        opcode;
        logic [3:0]        rd_addr;
    } ex_t;

    function automatic ex_t bubble();
        ex_t b;
        b        = '0;
        b.opcode = OPC_NOP;
        return b;
    endfunction

    logic [OPC_W-1:0]  opc;
    logic [3:0]        rd_addr, rs_addr;
    logic [15:0]       imm;
    logic              immf, addr_ok, und, hazard, issue, use_rd, use_rs;
    logic [DOPC_W-1:0] dopc;
    logic [W_DATA-1:0] imm_ext, rd_data, rs_data;
    ex_t               dec, ex_d, ex_q;

    assign opc     = inst_i[F_OPC_HI:F_OPC_LO];
    assign immf    = inst_i[F_IMMF];
    assign rd_addr = inst_i[F_RD_HI:F_RD_LO];
    assign rs_addr = inst_i[F_RS_HI:F_RS_LO];
    assign imm     = inst_i[F_IMM_HI:F_IMM_LO];

    assign addr_ok = ({1'b0, rd_addr} < 5'(N_REG)) && ({1'b0, rs_addr} < 5'(N_REG));
    assign und     = decode(opc)[DOPC_UND] | ~addr_ok;
    // Undefined instructions issue with every control stripped.
    assign dopc    = und ? '0 : decode(opc);

    assign use_rd = dopc[DOPC_INTE] | dopc[DOPC_LOGIC] | dopc[DOPC_SHIFT] | dopc[DOPC_SET] |
                    dopc[DOPC_ST] | dopc[DOPC_BR];
    assign use_rs = ((dopc[DOPC_INTE] | dopc[DOPC_LOGIC] | dopc[DOPC_SHIFT] | dopc[DOPC_SET]) &
                     ~immf) | dopc[DOPC_LD] | dopc[DOPC_ST];

    assign imm_ext = dopc[DOPC_IMM16] ? W_DATA'(imm) : W_DATA'($signed(imm));

    assign issue   = ~flush_i & ~stall_i & ~hazard & inst_valid_i;
    assign stall_o = (stall_i | hazard) & ~flush_i;

    id_sb_regfile #(
        .W_DATA (W_DATA),
        .N_REG  (N_REG)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .rd_addr_i    (rd_addr),
        .rs_addr_i    (rs_addr),
        .use_rd_i     (use_rd),
        .use_rs_i     (use_rs),
        .inst_valid_i (inst_valid_i),
        .sb_set_i     (issue & dopc[DOPC_RSV]),
        .wb_i         (wb_i),
        .wb_r_i       (wb_r_i),
        .wb_data_i    (wb_data_i),
        .rd_data_o    (rd_data),
        .rs_data_o    (rs_data),
        .hazard_o     (hazard),
        .sb_busy_o    (sb_busy_o)
    );

    always_comb begin
        dec           = '0;
        dec.valid     = inst_valid_i;
        dec.inte      = dopc[DOPC_INTE];
        dec.lgc       = dopc[DOPC_LOGIC];
        dec.shift     = dopc[DOPC_SHIFT];
        dec.ld        = dopc[DOPC_LD];
        dec.st        = dopc[DOPC_ST];
        dec.br        = dopc[DOPC_BR];
        dec.und       = und;
        dec.immf      = immf;
        dec.rsv       = dopc[DOPC_RSV];
        dec.rd_value  = rd_data;
        dec.rs_value  = rs_data;
        dec.imm_value = imm_ext;
        dec.pc        = pc_value_i;
        dec.opcode    = opc;
        dec.rd_addr   = rd_addr;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = bubble();
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = bubble();
        end else begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ex_q <= bubble();
        else      ex_q <= ex_d;
    end

    assign valid_o      = ex_q.valid;
    assign ctrl_inte_o  = ex_q.inte;
    assign ctrl_logic_o = ex_q.lgc;
    assign ctrl_shift_o = ex_q.shift;
    assign ctrl_ld_o    = ex_q.ld;
    assign ctrl_st_o    = ex_q.st;
    assign ctrl_br_o    = ex_q.br;
    assign und_o        = ex_q.und;
    assign immf_o       = ex_q.immf;
    assign rsv_o        = ex_q.rsv;
    assign rd_value_o   = ex_q.rd_value;
    assign rs_value_o   = ex_q.rs_value;
    assign imm_value_o  = ex_q.imm_value;
    assign pc_value_o   = ex_q.pc;
    assign opcode_o     = ex_q.opcode;
    assign rd_addr_o    = ex_q.rd_addr;

endmodule

// File: tb/tb_id_sb_stage.sv
// Directed bench for id_sb_stage: expected ID/EX contents are queued as each
// instruction is driven and compared one cycle later.
module tb_id_sb_stage;

    localparam int W_DATA = 32;
    localparam int N_REG  = 16;
    localparam int W_PC   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       inst_i = '0;
    logic              inst_valid_i = 1'b0;
    logic [W_PC-1:0]   pc_value_i = '0;
    logic              stall_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              wb_i = 1'b0;
    logic [3:0]        wb_r_i = '0;
    logic [W_DATA-1:0] wb_data_i = '0;
    logic              stall_o, valid_o, und_o, immf_o, rsv_o, sb_busy_o;
    logic              ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
    logic [W_DATA-1:0] rd_value_o, rs_value_o, imm_value_o;
    logic [W_PC-1:0]   pc_value_o;
    logic [6:0]        opcode_o;
    logic [3:0]        rd_addr_o;

    always #5 clk = ~clk;

    id_sb_stage #(.W_DATA(W_DATA), .N_REG(N_REG), .W_PC(W_PC)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .pc_value_i(pc_value_i), .stall_i(stall_i), .flush_i(flush_i), .wb_i(wb_i),
        .wb_r_i(wb_r_i), .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o),
        .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
        .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o), .und_o(und_o),
        .immf_o(immf_o), .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
        .imm_value_o(imm_value_o), .pc_value_o(pc_value_o), .opcode_o(opcode_o),
        .rd_addr_o(rd_addr_o), .rsv_o(rsv_o), .sb_busy_o(sb_busy_o)
    );

    // ctrl = {inte, logic, shift, ld, st, br}
    typedef struct packed {
        logic        valid;
        logic [5:0]  ctrl;
        logic        und;
        logic        immf;
        logic        rsv;
        logic [31:0] rdv;
        logic [31:0] rsv_v;
        logic [31:0] imm;
        logic [15:0] pc;
        logic [6:0]  opc;
        logic [3:0]  rda;
    } exp_t;

    localparam logic [5:0] C_INTE = 6'b100000, C_LOGIC = 6'b010000, C_SHIFT = 6'b001000;
    localparam logic [5:0] C_LD = 6'b000100, C_NONE = 6'b000000;

    exp_t exp_q[$];
    exp_t e_hold;
    int   n_assert = 0;
    int   n_fail = 0;

    function automatic exp_t ex(input logic v, input logic [5:0] c, input logic u, input logic im,
                                input logic r, input logic [31:0] rdv, input logic [31:0] rsv_v,
                                input logic [31:0] imm, input logic [15:0] pc,
                                input logic [6:0] op, input logic [3:0] rda);
        exp_t e;
        e = '{valid: v, ctrl: c, und: u, immf: im, rsv: r, rdv: rdv, rsv_v: rsv_v, imm: imm,
              pc: pc, opc: op, rda: rda};
        return e;
    endfunction

    function automatic exp_t bubble_e();
        return ex(1'b0, C_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, 7'h1E, 4'h0);
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {valid_o, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o,
             und_o, immf_o, rsv_o, rd_value_o, rs_value_o, imm_value_o, pc_value_o, opcode_o,
             rd_addr_o};
        return o;
    endfunction

    task automatic check_out(input string tag, input exp_t o, input exp_t e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic immf,
                         input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm,
                         input logic [15:0] pc);
        inst_i       = {opc, immf, rd, rs, imm};
        inst_valid_i = v;
        pc_value_i   = pc;
    endtask

    task automatic idle();
        drive(1'b0, 7'h1E, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0);
    endtask

    task automatic set_wb(input logic en, input logic [3:0] r, input logic [31:0] d);
        wb_i      = en;
        wb_r_i    = r;
        wb_data_i = d;
    endtask

    // One cycle: stall_o checked mid-cycle, ID/EX and sb_busy_o checked just after the edge.
    task automatic step(input string tag, input logic e_stall, input logic e_busy);
        exp_t e;
        @(negedge clk);
        check_bit({tag, " stall_o"}, stall_o, e_stall);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed no queued entry expected one", tag);
        end else begin
            e = exp_q.pop_front();
            check_out({tag, " idex"}, observed(), e);
        end
        check_bit({tag, " sb_busy_o"}, sb_busy_o, e_busy);
    endtask

    initial begin
        idle();
        set_wb(1'b0, 4'h0, 32'h0);
        #12;
        check_out("reset idex", observed(), bubble_e());
        check_bit("reset sb_busy_o", sb_busy_o, 1'b0);
        check_bit("reset stall_o", stall_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write-back bypass into rd of a same-cycle decode.
        set_wb(1'b1, 4'd3, 32'h12345678);
        drive(1'b1, 7'h00, 1'b0, 4'd3, 4'd1, 16'h0010, 16'h0100);
        exp_q.push_back(ex(1'b1, C_INTE, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0, 32'h10,
                           16'h0100, 7'h00, 4'd3));
        step("add bypass", 1'b0, 1'b1);

        set_wb(1'b1, 4'd3, 32'h12345678);
        idle();
        exp_q.push_back(bubble_e());
        step("wb r3 release", 1'b0, 1'b0);

        // ld r5 followed by a dependent add.
        set_wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 7'h18, 1'b0, 4'd5, 4'd2, 16'h0004, 16'h0104);
        exp_q.push_back(ex(1'b1, C_LD, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 16'h0104,
                           7'h18, 4'd5));
        step("ld r5", 1'b0, 1'b1);

        drive(1'b1, 7'h01, 1'b0, 4'd6, 4'd5, 16'h0000, 16'h0108);
        exp_q.push_back(bubble_e());
        step("raw stall 1", 1'b1, 1'b1);
        exp_q.push_back(bubble_e());
        step("raw stall 2", 1'b1, 1'b1);

        set_wb(1'b1, 4'd5, 32'hCAFEF00D);
        e_hold = ex(1'b1, C_INTE, 1'b0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 16'h0108,
                    7'h01, 4'd6);
        exp_q.push_back(e_hold);
        step("raw wb issue", 1'b0, 1'b1);

        // Downstream stall for 3 cycles; r6 released in the first stalled cycle.
        stall_i = 1'b1;
        set_wb(1'b1, 4'd6, 32'h00000066);
        drive(1'b1, 7'h10, 1'b0, 4'd7, 4'd3, 16'h0000, 16'h010C);
        exp_q.push_back(e_hold);
        step("stall hold 1", 1'b1, 1'b0);
        set_wb(1'b0, 4'd0, 32'h0);
        exp_q.push_back(e_hold);
        step("stall hold 2", 1'b1, 1'b0);
        exp_q.push_back(e_hold);
        step("stall hold 3", 1'b1, 1'b0);

        stall_i = 1'b0;
        exp_q.push_back(ex(1'b1, C_LOGIC, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0,
                           16'h010C, 7'h10, 4'd7));
        step("logic after stall", 1'b0, 1'b1);

        set_wb(1'b1, 4'd7, 32'h77);
        idle();
        exp_q.push_back(bubble_e());
        step("wb r7 release", 1'b0, 1'b0);

        // Undefined opcode and immediate extension.
        set_wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 7'h7F, 1'b0, 4'd1, 4'd1, 16'h1234, 16'h0200);
        exp_q.push_back(ex(1'b1, C_NONE, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 16'h0200,
                           7'h7F, 4'd1));
        step("undef 0x7f", 1'b0, 1'b0);

        drive(1'b1, 7'h08, 1'b1, 4'd2, 4'd0, 16'h8000, 16'h0204);
        exp_q.push_back(ex(1'b1, C_SHIFT, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h00008000,
                           16'h0204, 7'h08, 4'd2));
        step("shift zext", 1'b0, 1'b1);

        set_wb(1'b1, 4'd2, 32'h2222);
        drive(1'b1, 7'h00, 1'b1, 4'd4, 4'd0, 16'h8000, 16'h0208);
        exp_q.push_back(ex(1'b1, C_INTE, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'hFFFF8000,
                           16'h0208, 7'h00, 4'd4));
        step("add sext", 1'b0, 1'b1);

        // Flush while interlocked on r4.
        set_wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 7'h02, 1'b1, 4'd4, 4'd0, 16'h0001, 16'h020C);
        exp_q.push_back(bubble_e());
        step("rd hazard", 1'b1, 1'b1);
        flush_i = 1'b1;
        exp_q.push_back(bubble_e());
        step("flush in hazard", 1'b0, 1'b1);
        flush_i = 1'b0;
        exp_q.push_back(bubble_e());
        step("hazard after flush", 1'b1, 1'b1);
        set_wb(1'b1, 4'd4, 32'h4444);
        exp_q.push_back(ex(1'b1, C_INTE, 1'b0, 1'b1, 1'b1, 32'h4444, 32'h0, 32'h1, 16'h020C,
                           7'h02, 4'd4));
        step("issue on wb r4", 1'b0, 1'b1);

        // Asynchronous reset with r4 reserved and r3 holding data.
        set_wb(1'b0, 4'd0, 32'h0);
        idle();
        #3;
        rst = 1'b0;
        #1;
        check_out("midrun reset idex", observed(), bubble_e());
        check_bit("midrun reset sb_busy_o", sb_busy_o, 1'b0);
        check_bit("midrun reset stall_o", stall_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, 7'h00, 1'b0, 4'd3, 4'd3, 16'h0000, 16'h0300);
        exp_q.push_back(ex(1'b1, C_INTE, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 16'h0300,
                           7'h00, 4'd3));
        step("r3 after reset", 1'b0, 1'b1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_sb_stage.md
# id_sb_stage

Parametrised instruction-decode stage with an integrated register file, per-register scoreboard and hazard interlock. Decodes the 7-bit opcode into unit-select controls, reads two operands with same-cycle write-back bypass, and registers everything into the ID/EX pipeline register. Sits between fetch and execute. Unlike the previous decode stage it:
- inserts bubbles on read-after-write hazards;
- holds, rather than zeroes, its output on a downstream stall;
- supports flush;
- flags undefined opcodes.

## Interface
- W_DATA, 32, operand/register/immediate width (≥16)
- N_REG, 16, register count; power of 2, 2..16 (address field is always 4 bits)
- W_PC, 16, program-counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_i  in  32  instruction: opcode [31:25], immf [24], rd [23:20], rs [19:16], imm [15:0]
- inst_valid_i  in  1  inst_i is a real instruction
- pc_value_i  in  W_PC  PC of inst_i
- stall_i  in  1  execute cannot accept (hold)
- flush_i  in  1  discard current decode and output register
- wb_i, wb_r_i[3:0], wb_data_i[W_DATA]  in  write-back enable, address, data
- stall_o  out  1  fetch must hold inst_i
- valid_o  out  1  output register holds an issued instruction
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o  out  1 each  unit selects
- und_o  out  1  issued instruction was undefined
- immf_o  out  1  immediate flag
- rd_value_o, rs_value_o, imm_value_o  out  W_DATA  operands
- pc_value_o  out  W_PC  PC
- opcode_o  out  7  opcode
- rd_addr_o  out  4  destination address
- rsv_o  out  1  instruction writes rd
- sb_busy_o  out  1  any scoreboard bit set (combinational)

## Operation
- Decode uses the existing opcode map, yielding {inte, logic, shift, ld, st, br, imm16, rsv, und} plus a set bit:
  - integer 0x00–0x07: rsv=1, except 0x04 (rsv=0)
  - shift 0x08–0x0A, 0x0C–0x0D: imm16=1
  - logic 0x10–0x13; set 0x16–0x17; ld 0x18
  - st 0x19, rsv=0
  - br 0x1C–0x1D; jumps 0x1E–0x1F (no controls)
  - all other opcodes: und=1
- rd/rs addresses ≥ N_REG also set und. An undefined instruction issues with all controls 0, rsv=0, und_o=1.
- Operand use:
  - use_rd = inte|logic|shift|set|st|br
  - use_rs = ((inte|logic|shift|set) & ~immf) | ld | st
- Immediate: zero-extended when imm16=1, otherwise sign-extended from bit 15 to W_DATA.
- Register file: N_REG×W_DATA, written at posedge when wb_i is set. A read whose address matches wb_r_i while wb_i is set returns wb_data_i (bypass).
- Scoreboard: one bit per register.
  - Set on issue when rsv=1, at rd.
  - Cleared when wb_i is set, at wb_r_i.
  - Same-cycle set and clear on the same register: set wins.
- hazard = inst_valid_i & ((use_rd & sb[rd]) | (use_rs & sb[rs])). A scoreboard bit being cleared by this cycle's wb counts as not set.
- Priority, evaluated each cycle:
  1. flush_i: output register becomes a bubble; no issue; scoreboard is only cleared by wb.
  2. stall_i: output register holds; no issue.
  3. hazard: output becomes a bubble; no issue.
  4. Otherwise load the decoded instruction. valid_o = inst_valid_i; the scoreboard is set only if inst_valid_i.
- stall_o = (stall_i | hazard) & ~flush_i.
- Bubble: valid_o=0, all controls/und/immf/rsv=0, values 0, pc 0, opcode 7'b0011110, rd_addr 0.

## Timing
- Reset: output register = bubble, register file and scoreboard all 0, stall_o=0, sb_busy_o=0.
- Reset mid-operation clears outstanding reservations immediately.
- Latency 1 cycle from inst_i to outputs.
- A wb in cycle N unblocks a dependent instruction in that same cycle N (bypass); it issues at the edge ending cycle N.
- Back-to-back dependent instructions: the second stalls until the first's wb cycle.
- stall_i held for k cycles: outputs are stable for k cycles and scoreboard set occurs only once.

## Structure
- Package id_pkg holds:
  - opcode constants
  - dopc bit positions
  - NOP opcode 7'b0011110
  - field positions
  - the decode function
- Sub-module: id_sb_regfile (register file, scoreboard, bypass, hazard outputs). The top level holds decode, immediate extension and the pipeline register.

## Test plan
- Reset with rst=0 mid-run -> all outputs equal bubble, sb_busy_o=0; after release, a stored register reads 0.
- Write-back r3=0x12345678 and simultaneously decode add 0x00 using rd=r3 -> rd_value_o=0x12345678 next cycle.
- Issue ld r5, then an add reading r5 -> the add stalls (stall_o=1, bubble issued) until wb_r_i=5, then issues in the wb cycle.
- stall_i high for 3 cycles while valid_o=1 -> outputs unchanged for 3 cycles; sb bit set once.
- Opcode 0x7F -> und_o=1, ctrl_*_o=0, rsv_o=0; shift with imm 0x8000 -> imm_value_o=0x00008000; add with imm 0x8000 -> imm_value_o=0xFFFF8000.
- flush_i during a hazard stall -> bubble issued, stall_o=0, pending reservation stays until its wb.
